dll_lock_ctrl: RTL and testbench
================================

DLL_LOCK_CTRL -- requirements
Module: dll_lock_ctrl

Interface
REQ-001 The block SHALL have parameter SETTLE_CYC, default 8, the number of cycles per settle window (legal range 2..255).
REQ-002 The block SHALL have parameter LOCK_CNT, default 16, the number of consecutive dither evaluations needed to assert locked.
REQ-003 The block SHALL have parameter LOSS_CNT, default 3, the number of consecutive same-direction evaluations that drop locked.
REQ-004 clk_ext  in  1  single clock; all state changes on its rising edge.
REQ-005 rst  in  1  asynchronous, active-high reset.
REQ-006 start  in  1  one-cycle request to begin (or restart) the binary search.
REQ-007 hold  in  1  freezes the FSM, counters and code while high.
REQ-008 comp  in  1  phase-detector result: 1 = code too small (increase), 0 = code too large (decrease).
REQ-009 pd_reset  out  1  clears the phase detector for one cycle at the start of each settle window.
REQ-010 code  out  10  delay-line control word, split downstream as coarse [9:6] and fine [5:3]/[2:0].
REQ-011 busy  out  1  high in every state except IDLE.
REQ-012 locked  out  1  lock indication.
REQ-013 sat  out  1  high while TRACK is holding code at 0 or 1023.
REQ-014 state  out  3  current FSM state encoding.

Function
REQ-015 The FSM SHALL have states IDLE, S_SETTLE, S_EVAL, T_SETTLE and T_EVAL.
REQ-016 In IDLE, start SHALL load code=10'b10_0000_0000, set bit index to 9, and enter S_SETTLE.
REQ-017 Each settle state SHALL drive pd_reset high on its first cycle only, last exactly SETTLE_CYC cycles, then enter the matching EVAL state.
REQ-018 S_EVAL SHALL sample comp for one cycle: comp=0 clears code[idx], comp=1 keeps it.
REQ-019 When idx>0, S_EVAL SHALL also set code[idx-1], decrement idx, and return to S_SETTLE.
REQ-020 When idx=0, S_EVAL SHALL enter T_SETTLE; the search therefore takes exactly 10*(SETTLE_CYC+1) cycles from start to T_SETTLE.
REQ-021 T_EVAL SHALL apply code+1 on comp=1 and code-1 on comp=0, saturating at 1023 and 0, then return to T_SETTLE.
REQ-022 sat SHALL be set on a T_EVAL that is blocked by saturation and cleared on the next T_EVAL that moves code.
REQ-023 Lock counting SHALL compare each T_EVAL direction with the previous one: an opposite direction increments the dither count (saturating), and the same direction clears it.
REQ-024 locked SHALL rise on the T_EVAL where the dither count reaches LOCK_CNT.
REQ-025 While locked, LOSS_CNT consecutive same-direction T_EVALs SHALL clear locked and the dither count.
REQ-026 The first T_EVAL after the search SHALL have no previous direction and SHALL count as neither dither nor same.
REQ-027 A start in T_SETTLE or T_EVAL SHALL clear locked, sat and both lock counters, and restart the search as in REQ-016.
REQ-028 A start in S_SETTLE or S_EVAL SHALL be ignored.
REQ-029 While hold=1, all registers SHALL keep their values, pd_reset SHALL be 0, and a start arriving during hold SHALL be dropped.
REQ-030 When hold releases inside a settle window, the window SHALL resume its remaining count without re-pulsing pd_reset.
REQ-031 When start and hold are both high in the same cycle, hold SHALL win.
REQ-032 comp SHALL be sampled only in EVAL states; comp in every other state SHALL have no effect.

Reset
REQ-033 Asserting rst SHALL immediately force state=IDLE, code=0, idx=9, settle and lock counters=0, previous-direction=invalid, and pd_reset, busy, locked and sat=0.
REQ-034 Reset SHALL take effect mid-search or mid-track with no partial update surviving.

Structure
REQ-035 A shared package dll_pkg SHALL hold the state enumeration, CODE_W=10, CODE_MAX=1023 and the code-mid constant 512.
REQ-036 The settle timer SHALL be one sub-module, dll_settle_timer, with load/hold inputs and first-cycle and done outputs.
REQ-037 All outputs SHALL be registered.

Verification
REQ-038 SETTLE_CYC=8, comp = (code<300) -> after 90 cycles the block is in T_SETTLE with code=299 or 300, and pd_reset has pulsed 10 times.
REQ-039 Alternating comp 1,0,1,0 in TRACK with LOCK_CNT=16 -> locked rises on the 17th T_EVAL; then comp=1 three times -> locked falls on the 3rd.
REQ-040 code=1023 in TRACK with comp=1 held -> code stays at 1023 and sat=1; then comp=0 -> code=1022 and sat=0.
REQ-041 hold asserted for 5 cycles in the middle of S_SETTLE -> all outputs are frozen, and the search completes exactly 5 cycles later than nominal.
REQ-042 start during S_EVAL is ignored; start during T_SETTLE while locked -> locked=0 and code=512 on the next cycle.
REQ-043 rst asserted asynchronously mid-T_EVAL -> all outputs are 0 and state=IDLE before the next clock edge.

Source files
------------

// File: rtl/dll_pkg.sv
// Shared types and constants for the DLL lock controller: FSM encoding and
// delay-line code limits.
package dll_pkg;

  localparam int CODE_W = 10;
  localparam logic [CODE_W-1:0] CODE_MAX = 10'd1023;
  localparam logic [CODE_W-1:0] CODE_MID = 10'd512;
  localparam logic [3:0] IDX_MSB = 4'd9;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    S_SETTLE = 3'd1,
    S_EVAL   = 3'd2,
    T_SETTLE = 3'd3,
    T_EVAL   = 3'd4
  } dll_state_e;

endpackage

// File: rtl/dll_settle_timer.sv
// Settle-window down-counter: loaded at the start of each window, frozen by
// hold, and flags when the window has run its full length.
module dll_settle_timer #(
  parameter int SETTLE_CYC = 8
) (
  input  logic clk_ext,
  input  logic rst,
  input  logic load_i,
  input  logic hold_i,
  output logic first_o,
  output logic done_o
);

  logic [7:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (!hold_i) begin
      if (load_i) begin
        count_d = 8'(SETTLE_CYC - 1);
      end else if (count_q != 8'd0) begin
        count_d = count_q - 8'd1;
      end
    end
  end

  always_ff @(posedge clk_ext or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  // first_o marks the edge that opens a window; the caller registers it.
  assign first_o = load_i & ~hold_i;
  assign done_o  = (count_q == 8'd0);

endmodule

// File: rtl/dll_lock_ctrl.sv
// DLL lock controller: binary search of the delay-line code followed by
// +/-1 tracking with dither-based lock detection.
module dll_lock_ctrl
  import dll_pkg::*;
#(
  parameter int SETTLE_CYC = 8,
  parameter int LOCK_CNT   = 16,
  parameter int LOSS_CNT   = 3
) (
  input  logic              clk_ext,
  input  logic              rst,
  input  logic              start,
  input  logic              hold,
  input  logic              comp,
  output logic              pd_reset,
  output logic [CODE_W-1:0] code,
  output logic              busy,
  output logic              locked,
  output logic              sat,
  output logic [2:0]        state
);

  localparam logic [15:0] LOCK_LIM = 16'(LOCK_CNT);
  localparam logic [15:0] LOSS_LIM = 16'(LOSS_CNT);

  dll_state_e        state_q, state_d;
  logic [CODE_W-1:0] code_q, code_d;
  logic [3:0]        idx_q, idx_d;
  logic [15:0]       dither_q, dither_d;
  logic [15:0]       loss_q, loss_d;
  logic              prev_valid_q, prev_valid_d;
  logic              prev_up_q, prev_up_d;
  logic              locked_q, locked_d;
  logic              sat_q, sat_d;
  logic              pd_reset_q, busy_q;
  logic              restart, settle_load, settle_first, settle_done;

  dll_settle_timer #(.SETTLE_CYC(SETTLE_CYC)) u_timer (
    .clk_ext (clk_ext),
    .rst     (rst),
    .load_i  (settle_load),
    .hold_i  (hold),
    .first_o (settle_first),
    .done_o  (settle_done)
  );

  assign restart = start && !hold && (state_q inside {IDLE, T_SETTLE, T_EVAL});

  always_ff @(posedge clk_ext or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      code_q       <= '0;
      idx_q        <= IDX_MSB;
      dither_q     <= '0;
      loss_q       <= '0;
      prev_valid_q <= 1'b0;
      prev_up_q    <= 1'b0;
      locked_q     <= 1'b0;
      sat_q        <= 1'b0;
      pd_reset_q   <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      code_q       <= code_d;
      idx_q        <= idx_d;
      dither_q     <= dither_d;
      loss_q       <= loss_d;
      prev_valid_q <= prev_valid_d;
      prev_up_q    <= prev_up_d;
      locked_q     <= locked_d;
      sat_q        <= sat_d;
      pd_reset_q   <= settle_first;
      busy_q       <= (state_d != IDLE);
    end
  end

  always_comb begin
    state_d = state_q;
    if (!hold) begin
      case (state_q)
        IDLE:     if (start) state_d = S_SETTLE;
        S_SETTLE: if (settle_done) state_d = S_EVAL;
        S_EVAL:   state_d = (idx_q == 4'd0) ? T_SETTLE : S_SETTLE;
        T_SETTLE: begin
          if (start) begin
            state_d = S_SETTLE;
          end else if (settle_done) begin
            state_d = T_EVAL;
          end
        end
        T_EVAL:   state_d = start ? S_SETTLE : T_SETTLE;
        default:  state_d = IDLE;
      endcase
    end
  end

  // Every settle state is entered through a state change, so that edge opens the window.
  assign settle_load = (state_d != state_q) && (state_d == S_SETTLE || state_d == T_SETTLE);

  always_comb begin
    code_d       = code_q;
    idx_d        = idx_q;
    dither_d     = dither_q;
    loss_d       = loss_q;
    prev_valid_d = prev_valid_q;
    prev_up_d    = prev_up_q;
    locked_d     = locked_q;
    sat_d        = sat_q;
    if (!hold) begin
      if (restart) begin
        code_d       = CODE_MID;
        idx_d        = IDX_MSB;
        dither_d     = '0;
        loss_d       = '0;
        prev_valid_d = 1'b0;
        locked_d     = 1'b0;
        sat_d        = 1'b0;
      end else if (state_q == S_EVAL) begin
        if (!comp) code_d[idx_q] = 1'b0;
        if (idx_q != 4'd0) begin
          code_d[idx_q - 4'd1] = 1'b1;
          idx_d = idx_q - 4'd1;
        end
      end else if (state_q == T_EVAL) begin
        if (comp) begin
          if (code_q == CODE_MAX) begin
            sat_d = 1'b1;
          end else begin
            code_d = code_q + 10'd1;
            sat_d  = 1'b0;
          end
        end else begin
          if (code_q == '0) begin
            sat_d = 1'b1;
          end else begin
            code_d = code_q - 10'd1;
            sat_d  = 1'b0;
          end
        end
        // The first track step has no reference direction and is neutral.
        if (prev_valid_q) begin
          if (comp != prev_up_q) begin
            if (dither_q != LOCK_LIM) dither_d = dither_q + 16'd1;
            loss_d = '0;
            if (!locked_q && dither_d == LOCK_LIM) locked_d = 1'b1;
          end else begin
            dither_d = '0;
            if (locked_q && (loss_q + 16'd1 >= LOSS_LIM)) begin
              locked_d = 1'b0;
              loss_d   = '0;
            end else if (locked_q) begin
              loss_d = loss_q + 16'd1;
            end else begin
              loss_d = '0;
            end
          end
        end
        prev_valid_d = 1'b1;
        prev_up_d    = comp;
      end
    end
  end

  assign pd_reset = pd_reset_q;
  assign code     = code_q;
  assign busy     = busy_q;
  assign locked   = locked_q;
  assign sat      = sat_q;
  assign state    = state_q;

endmodule

// File: tb/tb_dll_lock_ctrl.sv
// Scoreboard bench for dll_lock_ctrl: each evaluation that lands in T_SETTLE
// is checked against a hand-computed expectation queued by the stimulus.
module tb_dll_lock_ctrl;
  import dll_pkg::*;

  logic       clk_ext = 1'b0;
  logic       rst, start, hold, comp;
  logic       pd_reset, busy, locked, sat;
  logic [9:0] code;
  logic [2:0] state;

  int testsRun = 0;
  int testsFailed = 0;
  int pdCount;
  int injected;

  typedef struct {
    string name;
    int    code;
    int    locked;
    int    sat;
  } expect_t;

  expect_t    expQ[$];
  expect_t    monExp;
  logic [2:0] prevState = 3'd0;

  always #5 clk_ext = ~clk_ext;

  dll_lock_ctrl #(.SETTLE_CYC(8), .LOCK_CNT(16), .LOSS_CNT(3)) dut (
    .clk_ext  (clk_ext),
    .rst      (rst),
    .start    (start),
    .hold     (hold),
    .comp     (comp),
    .pd_reset (pd_reset),
    .code     (code),
    .busy     (busy),
    .locked   (locked),
    .sat      (sat),
    .state    (state)
  );

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    testsRun++;
    if (actual !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic startVal, input logic holdVal, input logic compVal);
    start = startVal;
    hold  = holdVal;
    comp  = compVal;
  endtask

  task automatic waitState(input logic [2:0] target, input int maxCycles, input string name);
    int n;
    n = 0;
    while (state !== target && n < maxCycles) begin
      @(negedge clk_ext);
      n++;
    end
    if (state !== target) begin
      testsRun++;
      testsFailed++;
      $display("[TB] FAIL %s_timeout: state %0d, expected %0d within %0d cycles", name, state, target, maxCycles);
    end
  endtask

  // Called at a negedge; comp models a phase detector that says "increase" below threshold.
  task automatic runSearch(input int threshold, input int expCode, input string name);
    expQ.push_back(expect_t'{name, expCode, 0, 0});
    pdCount = 0;
    start = 1'b1;
    for (int i = 0; i < 90; i++) begin
      @(negedge clk_ext);
      start = 1'b0;
      if (pd_reset) pdCount++;
      comp = (int'(code) < threshold);
    end
    @(negedge clk_ext);
    checkOutput({name, "_state"}, 32'(state), 32'(T_SETTLE));
  endtask

  task automatic doEval(input logic c, input int expCode, input int expLocked, input int expSat, input string name);
    expQ.push_back(expect_t'{name, expCode, expLocked, expSat});
    comp = c;
    waitState(T_EVAL, 20, name);
    @(negedge clk_ext);
  endtask

  always @(negedge clk_ext) begin
    if (state == T_SETTLE && (prevState == S_EVAL || prevState == T_EVAL)) begin
      if (expQ.size() == 0) begin
        testsRun++;
        testsFailed++;
        $display("[TB] FAIL unexpected_result: code %0d locked %0d sat %0d, expected no result", code, locked, sat);
      end else begin
        monExp = expQ.pop_front();
        checkOutput({monExp.name, "_code"}, 32'(code), monExp.code);
        checkOutput({monExp.name, "_locked"}, 32'(locked), monExp.locked);
        checkOutput({monExp.name, "_sat"}, 32'(sat), monExp.sat);
      end
    end
    prevState = state;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst = 1'b1;
    applyStimulus(1'b0, 1'b0, 1'b0);
    repeat (3) @(negedge clk_ext);
    checkOutput("reset_state", 32'(state), 32'(IDLE));
    checkOutput("reset_code", 32'(code), 0);
    checkOutput("reset_busy", 32'(busy), 0);
    checkOutput("reset_pd", 32'(pd_reset), 0);
    rst = 1'b0;
    @(negedge clk_ext);
    checkOutput("idle_busy", 32'(busy), 0);

    runSearch(300, 299, "search300");
    checkOutput("search300_pd_pulses", pdCount, 10);

    for (int n = 1; n <= 20; n++) begin
      doEval((n <= 17) ? logic'(n % 2) : 1'b1,
             (n <= 17) ? ((n % 2 == 1) ? 300 : 299) : 300 + (n - 17),
             (n >= 17 && n <= 19) ? 1 : 0, 0, $sformatf("lock_eval%0d", n));
    end
    for (int n = 21; n <= 36; n++) begin
      doEval(logic'(n % 2 == 0), (n % 2 == 1) ? 302 : 303, (n == 36) ? 1 : 0, 0,
             $sformatf("relock_eval%0d", n));
    end

    checkOutput("pre_restart_locked", 32'(locked), 1);
    applyStimulus(1'b1, 1'b0, 1'b0);
    @(negedge clk_ext);
    start = 1'b0;
    checkOutput("restart_locked", 32'(locked), 0);
    checkOutput("restart_code", 32'(code), 512);
    checkOutput("restart_state", 32'(state), 32'(S_SETTLE));
    checkOutput("restart_pd", 32'(pd_reset), 1);

    // Hold for five edges early in the first window, and a start inside S_EVAL.
    expQ.push_back(expect_t'{"hold_search", 299, 0, 0});
    pdCount = 1;
    injected = 0;
    for (int i = 1; i <= 94; i++) begin
      @(negedge clk_ext);
      start = 1'b0;
      if (pd_reset) pdCount++;
      if (i >= 3 && i <= 7) begin
        checkOutput($sformatf("hold%0d_code", i), 32'(code), 512);
        checkOutput($sformatf("hold%0d_state", i), 32'(state), 32'(S_SETTLE));
        checkOutput($sformatf("hold%0d_pd", i), 32'(pd_reset), 0);
      end
      hold = (i >= 2 && i <= 6);
      if (injected == 0 && state == S_EVAL) begin
        start = 1'b1;
        injected = 1;
      end
      comp = (int'(code) < 300);
    end
    checkOutput("hold_not_early", 32'(state), 32'(S_EVAL));
    @(negedge clk_ext);
    checkOutput("hold_done_state", 32'(state), 32'(T_SETTLE));
    checkOutput("hold_pd_pulses", pdCount, 10);

    runSearch(1024, 1023, "search_max");
    doEval(1'b1, 1023, 0, 1, "sat_hi1");
    doEval(1'b1, 1023, 0, 1, "sat_hi2");
    doEval(1'b0, 1022, 0, 0, "sat_hi_release");
    runSearch(0, 0, "search_min");
    doEval(1'b0, 0, 0, 1, "sat_lo");
    doEval(1'b1, 1, 0, 0, "sat_lo_release");

    comp = 1'b1;
    waitState(T_EVAL, 20, "rst_wait");
    #2 rst = 1'b1;
    #1;
    checkOutput("async_rst_state", 32'(state), 32'(IDLE));
    checkOutput("async_rst_code", 32'(code), 0);
    checkOutput("async_rst_busy", 32'(busy), 0);
    checkOutput("async_rst_locked", 32'(locked), 0);
    checkOutput("async_rst_sat", 32'(sat), 0);
    checkOutput("async_rst_pd", 32'(pd_reset), 0);
    @(negedge clk_ext);
    rst = 1'b0;
    @(negedge clk_ext);
    applyStimulus(1'b1, 1'b0, 1'b0);
    @(negedge clk_ext);
    start = 1'b0;
    checkOutput("post_rst_start_code", 32'(code), 512);
    checkOutput("post_rst_start_busy", 32'(busy), 1);

    checkOutput("scoreboard_empty", expQ.size(), 0);
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
